// File: rtl/light_pkg.sv
// Shared level encodings, PWM duty constants and the level-to-duty mapping
// for the room light sequencer.
package light_pkg;

    typedef enum logic [1:0] {
        LVL_OFF  = 2'd0,
        LVL_LOW  = 2'd1,
        LVL_MID  = 2'd2,
        LVL_HIGH = 2'd3
    } level_e;

    localparam int unsigned DUTY_W = 4;

    // Duty is compared against a 3-bit counter, so 8 means always on.
    localparam logic [DUTY_W-1:0] DUTY_OFF  = 4'd0;
    localparam logic [DUTY_W-1:0] DUTY_LOW  = 4'd2;
    localparam logic [DUTY_W-1:0] DUTY_MID  = 4'd5;
    localparam logic [DUTY_W-1:0] DUTY_HIGH = 4'd8;

    function automatic logic [DUTY_W-1:0] level_to_duty(input level_e lvl);
        logic [DUTY_W-1:0] duty;
        case (lvl)
            LVL_LOW:  duty = DUTY_LOW;
            LVL_MID:  duty = DUTY_MID;
            LVL_HIGH: duty = DUTY_HIGH;
            default:  duty = DUTY_OFF;
        endcase
        return duty;
    endfunction

endpackage

// File: rtl/light_press_classifier.sv
// Turns a debounced button level into one-cycle short / long press events,
// timed in 1 ms ticks.
module light_press_classifier #(
    parameter int unsigned LONG_MS = 1000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button,
    input  logic tick,
    output logic o_short,
    output logic o_long
);

    localparam int unsigned HOLD_W = $clog2(LONG_MS + 1);
    localparam logic [HOLD_W-1:0] LONG_CNT = HOLD_W'(LONG_MS);

    logic              btn_q;
    logic              armed_q, armed_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rise, fall;

    assign rise = i_button & ~btn_q;
    assign fall = ~i_button & btn_q;

    always_comb begin
        hold_d  = hold_q;
        armed_d = armed_q;
        o_short = 1'b0;
        o_long  = 1'b0;
        if (rise) begin
            hold_d  = '0;
            armed_d = 1'b1;
        end else if (i_button && tick && hold_q != LONG_CNT) begin
            hold_d = hold_q + 1'b1;
            // Disarming here keeps the eventual release from also producing a short event.
            if (armed_q && hold_d == LONG_CNT) begin
                o_long  = 1'b1;
                armed_d = 1'b0;
            end
        end
        if (fall) begin
            o_short = armed_q;
            armed_d = 1'b0;
        end
    end

    // History resets to pressed so a button held through reset is ignored until released.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            btn_q   <= 1'b1;
            armed_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            btn_q   <= i_button;
            armed_q <= armed_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: rtl/light_sequencer.sv
// Room light controller: steps brightness from short/long presses, auto-offs
// after an idle timeout with a pre-off warning, and drives a PWM lamp output.
module light_sequencer
    import light_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned LONG_MS    = 1000,
    parameter int unsigned TIMEOUT_MS = 60000,
    parameter int unsigned WARN_MS    = 5000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_button,
    input  logic       i_motion,
    output logic [1:0] o_light,
    output logic       o_pwm,
    output logic       o_warn
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_MS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_MS - 1);
    localparam logic [IDLE_W-1:0] WARN_AT   = IDLE_W'(TIMEOUT_MS - WARN_MS);

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic              short_ev, long_ev;
    level_e            state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              idle_clr, timeout;
    logic              warn_q, warn_d;
    logic [2:0]        pwm_cnt_q;
    logic              pwm_q;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    light_press_classifier #(
        .LONG_MS (LONG_MS)
    ) u_press (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_button (i_button),
        .tick     (tick),
        .o_short  (short_ev),
        .o_long   (long_ev)
    );

    assign timeout = (state_q != LVL_OFF) && tick && (idle_q == IDLE_LAST);

    // Priority: press events, then motion, then timeout.
    always_comb begin
        state_d  = state_q;
        idle_clr = 1'b0;
        if (short_ev) begin
            idle_clr = 1'b1;
            unique case (state_q)
                LVL_OFF:  state_d = LVL_LOW;
                LVL_LOW:  state_d = LVL_MID;
                LVL_MID:  state_d = LVL_HIGH;
                LVL_HIGH: state_d = LVL_OFF;
                default:  state_d = LVL_OFF;
            endcase
        end else if (long_ev) begin
            idle_clr = 1'b1;
            state_d  = (state_q == LVL_OFF) ? LVL_HIGH : LVL_OFF;
        end else if (i_motion && state_q != LVL_OFF) begin
            idle_clr = 1'b1;
        end else if (timeout) begin
            state_d = LVL_OFF;
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (state_d == LVL_OFF || idle_clr) begin
            idle_d = '0;
        end else if (tick) begin
            idle_d = idle_q + 1'b1;
        end
        warn_d = (state_d != LVL_OFF) && (idle_d >= WARN_AT);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= LVL_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idle_q    <= '0;
            warn_q    <= 1'b0;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            warn_q    <= warn_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_q     <= ({1'b0, pwm_cnt_q} < level_to_duty(state_q));
        end
    end

    assign o_light = state_q;
    assign o_warn  = warn_q;
    assign o_pwm   = pwm_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer with millisecond timing shrunk to a few cycles.
`timescale 1ns/1ps
module tb_light_sequencer;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned LONG_MS    = 5;
    localparam int unsigned TIMEOUT_MS = 20;
    localparam int unsigned WARN_MS    = 5;
    localparam int          WARN_AT    = TIMEOUT_MS - WARN_MS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button = 1'b0;
    logic       motion = 1'b0;
    logic [1:0] light;
    logic       pwm;
    logic       warn;

    int errors = 0;
    int checks = 0;
    int tb_cnt;

    typedef struct packed {
        logic [1:0] light;
        logic       warn;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    light_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .LONG_MS    (LONG_MS),
        .TIMEOUT_MS (TIMEOUT_MS),
        .WARN_MS    (WARN_MS)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_button (button),
        .i_motion (motion),
        .o_light  (light),
        .o_pwm    (pwm),
        .o_warn   (warn)
    );

    // Independent ms-tick reference, free-running from reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
    end

    // Called at a falling edge: does the cycle now starting carry a tick?
    function automatic bit tick_now();
        return tb_cnt == TICK_DIV - 1;
    endfunction

    task automatic hold(input int n);
        button = 1'b1;
        repeat (n) @(negedge clk);
        button = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (light !== 2'd0 || pwm !== 1'b0 || warn !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: light=%0d pwm=%b warn=%b, want 0 0 0", light, pwm, warn);
        end
        rst_n = 1'b1;
        sb_q.push_back(exp_t'{light: 2'd0, warn: 1'b0});
        repeat (2) @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (light !== e.light || warn !== e.warn) begin
            errors++;
            $display("FAIL reset_release: light=%0d warn=%b, want %0d %b",
                     light, warn, e.light, e.warn);
        end
    endtask

    task automatic test_short_presses();
        exp_t e;
        logic [1:0] prev, want;
        for (int i = 0; i < 4; i++) begin
            prev = 2'(i);
            want = 2'(i + 1);
            hold(8);
            checks++;
            if (light !== prev) begin
                errors++;
                $display("FAIL short_early: light=%0d, want %0d", light, prev);
            end
            sb_q.push_back(exp_t'{light: want, warn: 1'b0});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL short_step%0d: light=%0d warn=%b, want %0d %b",
                         i, light, warn, e.light, e.warn);
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_long_hold(input logic [1:0] from, input logic [1:0] to);
        exp_t e;
        int ticks;
        logic [1:0] lvl;
        ticks = 0;
        lvl = from;
        button = 1'b1;
        for (int c = 0; c < 32; c++) begin
            // Cycle 0 is the rising edge itself, which only clears the hold count.
            if (c >= 1 && tick_now()) begin
                ticks++;
                if (ticks == LONG_MS) lvl = to;
            end
            sb_q.push_back(exp_t'{light: lvl, warn: 1'b0});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL long_hold c=%0d: light=%0d warn=%b, want %0d %b",
                         c, light, warn, e.light, e.warn);
            end
        end
        button = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sb_q.push_back(exp_t'{light: to, warn: 1'b0});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL long_release c=%0d: light=%0d warn=%b, want %0d %b",
                         c, light, warn, e.light, e.warn);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int idle;
        logic [1:0] lvl;
        hold(8);
        sb_q.push_back(exp_t'{light: 2'd1, warn: 1'b0});
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (light !== e.light || warn !== e.warn) begin
            errors++;
            $display("FAIL timeout_setup: light=%0d warn=%b, want %0d %b",
                     light, warn, e.light, e.warn);
        end
        idle = 0;
        for (int c = 0; c < 120 && idle < TIMEOUT_MS; c++) begin
            if (tick_now()) idle++;
            lvl = (idle >= TIMEOUT_MS) ? 2'd0 : 2'd1;
            sb_q.push_back(exp_t'{light: lvl, warn: (lvl != 0 && idle >= WARN_AT)});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL timeout_run idle=%0d: light=%0d warn=%b, want %0d %b",
                         idle, light, warn, e.light, e.warn);
            end
        end
    endtask

    task automatic test_motion();
        exp_t e;
        int idle;
        bit done;
        logic [1:0] lvl;
        hold(8);
        sb_q.push_back(exp_t'{light: 2'd1, warn: 1'b0});
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (light !== e.light || warn !== e.warn) begin
            errors++;
            $display("FAIL motion_setup: light=%0d warn=%b, want %0d %b",
                     light, warn, e.light, e.warn);
        end
        idle = 0;
        done = 1'b0;
        lvl = 2'd1;
        for (int c = 0; c < 200 && lvl != 0; c++) begin
            motion = 1'b0;
            if (!done && idle == 17) begin
                motion = 1'b1;
                done = 1'b1;
                idle = 0;
            end else if (tick_now()) begin
                idle++;
            end
            if (idle >= TIMEOUT_MS) lvl = 2'd0;
            sb_q.push_back(exp_t'{light: lvl, warn: (lvl != 0 && idle >= WARN_AT)});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL motion_run idle=%0d: light=%0d warn=%b, want %0d %b",
                         idle, light, warn, e.light, e.warn);
            end
        end
        motion = 1'b0;
        for (int c = 0; c < 6; c++) begin
            motion = (c == 0);
            sb_q.push_back(exp_t'{light: 2'd0, warn: 1'b0});
            @(negedge clk);
            motion = 1'b0;
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL motion_in_off: light=%0d warn=%b, want %0d %b",
                         light, warn, e.light, e.warn);
            end
        end
    endtask

    task automatic test_press_vs_timeout();
        exp_t e;
        int idle, post;
        bit pressed, released;
        logic [1:0] lvl;
        for (int i = 1; i <= 2; i++) begin
            hold(8);
            sb_q.push_back(exp_t'{light: 2'(i), warn: 1'b0});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL pvt_setup: light=%0d warn=%b, want %0d %b",
                         light, warn, e.light, e.warn);
            end
            if (i == 1) repeat (2) @(negedge clk);
        end
        lvl = 2'd2;
        idle = 0;
        post = 0;
        pressed = 1'b0;
        released = 1'b0;
        for (int c = 0; c < 200 && post < 8; c++) begin
            if (!pressed && idle == 17) begin
                button = 1'b1;
                pressed = 1'b1;
            end
            // Release lands on the very tick that would otherwise time out MID.
            if (pressed && !released && idle == TIMEOUT_MS - 1 && tick_now()) begin
                button = 1'b0;
                released = 1'b1;
                lvl = 2'd3;
                idle = 0;
            end else if (tick_now()) begin
                idle++;
            end
            if (lvl != 0 && idle >= TIMEOUT_MS) lvl = 2'd0;
            if (released) post++;
            sb_q.push_back(exp_t'{light: lvl, warn: (lvl != 0 && idle >= WARN_AT)});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL press_vs_timeout idle=%0d: light=%0d warn=%b, want %0d %b",
                         idle, light, warn, e.light, e.warn);
            end
        end
        test_long_hold(2'd3, 2'd0);
    endtask

    task automatic test_pwm();
        exp_t e;
        int want[4] = '{0, 16, 40, 64};
        int cnt;
        for (int lvl = 0; lvl < 5; lvl++) begin
            if (lvl > 0) begin
                hold(8);
                sb_q.push_back(exp_t'{light: 2'(lvl), warn: 1'b0});
                @(negedge clk);
                e = sb_q.pop_front();
                checks++;
                if (light !== e.light || warn !== e.warn) begin
                    errors++;
                    $display("FAIL pwm_level: light=%0d warn=%b, want %0d %b",
                             light, warn, e.light, e.warn);
                end
            end
            if (lvl == 4) break;
            repeat (2) @(negedge clk);
            cnt = 0;
            repeat (64) begin
                @(negedge clk);
                if (pwm === 1'b1) cnt++;
            end
            checks++;
            if (cnt != want[lvl]) begin
                errors++;
                $display("FAIL pwm_duty lvl=%0d: highs=%0d, want %0d", lvl, cnt, want[lvl]);
            end
            motion = 1'b1;
            @(negedge clk);
            motion = 1'b0;
        end
    endtask

    task automatic test_reset_held();
        exp_t e;
        button = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (c == 32) button = 1'b0;
            sb_q.push_back(exp_t'{light: 2'd0, warn: 1'b0});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL held_through_reset c=%0d: light=%0d warn=%b, want %0d %b",
                         c, light, warn, e.light, e.warn);
            end
        end
        hold(8);
        sb_q.push_back(exp_t'{light: 2'd1, warn: 1'b0});
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (light !== e.light || warn !== e.warn) begin
            errors++;
            $display("FAIL repress_after_reset: light=%0d warn=%b, want %0d %b",
                     light, warn, e.light, e.warn);
        end
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        for (int i = 2; i <= 3; i++) begin
            hold(8);
            sb_q.push_back(exp_t'{light: 2'(i), warn: 1'b0});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL midhold_setup: light=%0d warn=%b, want %0d %b",
                         light, warn, e.light, e.warn);
            end
        end
        button = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (pwm !== 1'b1) begin
            errors++;
            $display("FAIL pwm_high_before_reset: pwm=%b, want 1", pwm);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (light !== 2'd0 || pwm !== 1'b0 || warn !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: light=%0d pwm=%b warn=%b, want 0 0 0", light, pwm, warn);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (c == 32) button = 1'b0;
            sb_q.push_back(exp_t'{light: 2'd0, warn: 1'b0});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (light !== e.light || warn !== e.warn) begin
                errors++;
                $display("FAIL post_reset_hold c=%0d: light=%0d warn=%b, want %0d %b",
                         c, light, warn, e.light, e.warn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_presses();
        test_long_hold(2'd0, 2'd3);
        test_long_hold(2'd3, 2'd0);
        test_timeout();
        test_motion();
        test_press_vs_timeout();
        test_pwm();
        test_reset_held();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
